kf_in_stage: RTL and testbench

KF_IN_STAGE -- requirements
Module: kf_in_stage

---
 rtl/kf_pkg.sv | 14 +
 rtl/kf_sync_fifo.sv | 50 +++++
 rtl/kf_in_stage.sv | 136 +++++++++++++
 tb/tb_kf_in_stage.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf_pkg.sv
// Shared constants and FSM encoding for the Kalman-filter input stage.
package kf_pkg;

    localparam int unsigned KF_W    = 24;
    localparam int unsigned KF_FRAC = 14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_ACK    = 2'd2,
        ST_RUN    = 2'd3
    } kf_state_t;

endpackage

// File: rtl/kf_sync_fifo.sv
// Synchronous FIFO with occupancy output; DEPTH must be a power of two so
// the pointers wrap naturally.
module kf_sync_fifo #(
    parameter int unsigned W     = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/kf_in_stage.sv
// Input stage: buffers samples and hands them one at a time to the filter
// sequencer. Define KF_IN_TIMEOUT_EN to build in the ACK watchdog.
module kf_in_stage
    import kf_pkg::*;
#(
    parameter int unsigned W      = KF_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ACK_TO = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [W-1:0]             s_data,
    output logic                     s_ready,
    input  logic                     kf_ready,
    output logic                     kf_start,
    output logic [W-1:0]             kf_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              sample_cnt,
    output logic                     err_timeout
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("kf_in_stage: DEPTH must be a power of two and at least 2");
    end
    if (ACK_TO == 0) begin : g_bad_ack_to
        $error("kf_in_stage: ACK_TO must be nonzero");
    end

    kf_state_t      state;
    kf_state_t      state_nxt;
    logic           fifo_push;
    logic           fifo_pop;
    logic           run_done;
    logic           ack_expired;
    logic [W-1:0]   fifo_dout;

    kf_sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (s_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .level (level)
    );

    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    assign s_ready   = (level != LW'(DEPTH)) || fifo_pop;
    assign fifo_push = s_valid && s_ready;
    assign kf_data   = (level != '0) ? fifo_dout : '0;

`ifdef KF_IN_TIMEOUT_EN
    localparam int unsigned TW = $clog2(ACK_TO + 1);

    logic [TW-1:0] ack_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ST_ACK) begin
            ack_cnt <= '0;
        end else begin
            ack_cnt <= ack_cnt + TW'(1);
        end
    end

    assign ack_expired = (state == ST_ACK) && kf_ready && (ack_cnt == TW'(ACK_TO - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (ack_expired) begin
            err_timeout <= 1'b1;
        end
    end
`else
    assign ack_expired = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (level != '0 && kf_ready) begin
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_nxt = ST_ACK;
            end
            ST_ACK: begin
                if (!kf_ready) begin
                    state_nxt = ST_RUN;
                end else if (ack_expired) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (kf_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        kf_start = (state == ST_LAUNCH);
        busy     = (state != ST_IDLE);
        run_done = (state == ST_RUN) && kf_ready;
        fifo_pop = run_done || ack_expired;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (run_done) begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_kf_in_stage.sv
// Directed bench for kf_in_stage with a queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_kf_in_stage;

    localparam int W      = 24;
    localparam int DEPTH  = 4;
    localparam int ACK_TO = 15;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          s_ready;
    logic          kf_ready;
    logic          kf_start;
    logic [W-1:0]  kf_data;
    logic          busy;
    logic [LW-1:0] level;
    logic [15:0]   sample_cnt;
    logic          err_timeout;

    bit filt_en = 1'b0;
    bit filt_ready = 1'b1;
    bit man_ready = 1'b1;
    bit start_seen = 1'b0;
    int filt_len = 10;
    int filt_left = 0;

    assign kf_ready = filt_en ? filt_ready : man_ready;

    kf_in_stage #(
        .W      (W),
        .DEPTH  (DEPTH),
        .ACK_TO (ACK_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .kf_ready    (kf_ready),
        .kf_start    (kf_start),
        .kf_data     (kf_data),
        .busy        (busy),
        .level       (level),
        .sample_cnt  (sample_cnt),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // reference model state
    logic [W-1:0] q[$];
    bit           m_launch, m_inflight, m_acked, m_err;
    int           m_ackcnt;
    logic [15:0]  m_cnt;
    int           m_runs;
    int           start_count = 0;
    int           last_start_cyc = -1;
    logic [W-1:0] last_start_data = '0;
    int           push_cyc = -1;

    bit           pop_now, drop_now, e_start, e_busy, e_rdy;
    logic [W-1:0] e_data;
    logic [LW-1:0] e_lvl;
    int           sz;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // filter sequencer model: ready drops the cycle after a start, for filt_len cycles
    initial forever begin
        @(negedge clk);
        start_seen = (kf_start === 1'b1);
        @(posedge clk);
        #1;
        if (start_seen && filt_en) filt_left = filt_len;
        if (filt_left > 0) begin
            filt_ready = 1'b0;
            filt_left--;
        end else begin
            filt_ready = 1'b1;
        end
    end

    task automatic summary_and_finish();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic model_reset();
        q.delete();
        m_launch = 0; m_inflight = 0; m_acked = 0; m_err = 0;
        m_ackcnt = 0; m_cnt = '0; m_runs = 0;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) begin
            model_reset();
        end else if (chk_en) begin
            sz = q.size();
            pop_now  = m_inflight && m_acked && (kf_ready === 1'b1);
            drop_now = 1'b0;
`ifdef KF_IN_TIMEOUT_EN
            drop_now = m_inflight && !m_acked && (kf_ready === 1'b1) && (m_ackcnt == ACK_TO - 1);
`endif
            e_start = m_launch;
            e_busy  = m_launch || m_inflight;
            e_rdy   = (sz != DEPTH) || pop_now || drop_now;
            e_data  = (sz != 0) ? q[0] : '0;
            e_lvl   = LW'(sz);
            checks++;
            if (kf_start !== e_start || busy !== e_busy || s_ready !== e_rdy || level !== e_lvl ||
                kf_data !== e_data || sample_cnt !== m_cnt || err_timeout !== m_err) begin
                errors++;
                $display("FAIL model_cmp cyc=%0d got start=%b busy=%b rdy=%b lvl=%0d data=%h cnt=%0d err=%b want start=%b busy=%b rdy=%b lvl=%0d data=%h cnt=%0d err=%b",
                         cyc, kf_start, busy, s_ready, level, kf_data, sample_cnt, err_timeout,
                         e_start, e_busy, e_rdy, e_lvl, e_data, m_cnt, m_err);
            end
            if (kf_start === 1'b1) begin
                start_count++;
                last_start_cyc  = cyc;
                last_start_data = kf_data;
            end
            if (m_launch) begin
                m_launch = 0; m_inflight = 1; m_acked = 0; m_ackcnt = 0;
            end else if (m_inflight && !m_acked) begin
                if (kf_ready === 1'b0) m_acked = 1;
                else if (drop_now) begin m_err = 1; m_inflight = 0; end
                else m_ackcnt++;
            end else if (pop_now) begin
                m_inflight = 0; m_cnt++; m_runs++;
            end else if (!m_inflight && sz != 0 && kf_ready === 1'b1) begin
                m_launch = 1;
            end
            if (pop_now || drop_now) void'(q.pop_front());
            if (s_valid && e_rdy) q.push_back(s_data);
            if (errors >= 100) summary_and_finish();
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic drive_phase();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic push_one(input logic [W-1:0] d);
        bit ok = 0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            at_sample();
            if (s_ready === 1'b1) begin
                ok = 1;
                push_cyc = cyc;
            end
            drive_phase();
        end
        s_valid = 1'b0;
        chk("push_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_starts(input int target, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            at_sample();
            if (start_count >= target) ok = 1;
        end
        chk("start_seen", 64'(ok), 64'd1);
    endtask

    initial begin
        int sc0;
        bit ok;

        // reset state
        repeat (3) drive_phase();
        rst = 1'b0;
        chk_en = 1'b1;
        at_sample();
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(sample_cnt), 64'd0);
        drive_phase();

        // single run, filter busy for 10 cycles
        filt_len = 10;
        filt_en  = 1'b1;
        push_one(24'h004000);
        wait_starts(1, 20);
        chk("start_latency", 64'(last_start_cyc - push_cyc), 64'd2);
        chk("start_data", 64'(last_start_data), 64'h004000);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            at_sample();
            if (busy === 1'b0) ok = 1;
        end
        chk("run1_done", 64'(ok), 64'd1);
        chk("run1_cnt", 64'(sample_cnt), 64'd1);
        chk("run1_level", 64'(level), 64'd0);
        drive_phase();

        // fill with filter stalled
        filt_en   = 1'b0;
        man_ready = 1'b0;
        sc0 = start_count;
        for (int i = 1; i <= 4; i++) push_one(W'(i));
        s_valid = 1'b1;
        s_data  = W'(5);
        for (int i = 0; i < 5; i++) begin
            at_sample();
            chk("full_s_ready", 64'(s_ready), 64'd0);
            chk("full_level", 64'(level), 64'd4);
            drive_phase();
        end
        chk("stall_no_start", 64'(start_count), 64'(sc0));

        // 5th sample accepted on the completion-pop cycle
        filt_len = 3;
        filt_en  = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            at_sample();
            if (s_ready === 1'b1) begin
                ok = 1;
                chk("pop_push_level", 64'(level), 64'd4);
                chk("pop_push_busy", 64'(busy), 64'd1);
            end
            drive_phase();
        end
        s_valid  = 1'b0;
        filt_len = 20;
        chk("pop_push_seen", 64'(ok), 64'd1);
        at_sample();
        chk("pop_push_level_after", 64'(level), 64'd4);
        chk("pop_push_cnt", 64'(sample_cnt), 64'd2);
        drive_phase();

        // reset mid-run with level 3
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            at_sample();
            if (level === LW'(3) && busy === 1'b1 && kf_ready === 1'b0) ok = 1;
        end
        chk("reach_level3_run", 64'(ok), 64'd1);
        repeat (3) drive_phase();
        rst = 1'b1;
        drive_phase();
        rst = 1'b0;
        at_sample();
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        chk("midrun_rst_level", 64'(level), 64'd0);
        chk("midrun_rst_cnt", 64'(sample_cnt), 64'd0);
        chk("midrun_rst_start", 64'(kf_start), 64'd0);
        chk("midrun_rst_err", 64'(err_timeout), 64'd0);
        drive_phase();

        // filter never acknowledges
        filt_en   = 1'b0;
        man_ready = 1'b1;
        sc0 = start_count;
        push_one(24'h00ABCD);
        wait_starts(sc0 + 1, 20);
`ifdef KF_IN_TIMEOUT_EN
        repeat (ACK_TO + 1) at_sample();
        chk("to_err", 64'(err_timeout), 64'd1);
        chk("to_level", 64'(level), 64'd0);
        chk("to_cnt", 64'(sample_cnt), 64'd0);
        chk("to_busy", 64'(busy), 64'd0);
`else
        repeat (40) at_sample();
        chk("noto_busy", 64'(busy), 64'd1);
        chk("noto_err", 64'(err_timeout), 64'd0);
        chk("noto_level", 64'(level), 64'd1);
        chk("noto_starts", 64'(start_count), 64'(sc0 + 1));
`endif
        drive_phase();
        rst = 1'b1;
        drive_phase();
        rst = 1'b0;

        // 65536 back-to-back runs wrap the counter
        filt_len = 1;
        filt_en  = 1'b1;
        s_valid  = 1'b1;
        for (int i = 0; i < 300000 && m_runs < 65536; i++) begin
            drive_phase();
            s_data = W'(cyc * 13);
        end
        s_valid = 1'b0;
        chk("wrap_runs", 64'(m_runs), 64'd65536);
        at_sample();
        chk("wrap_cnt", 64'(sample_cnt), 64'd0);
        repeat (2) drive_phase();

        summary_and_finish();
    end

    initial begin
        #4000000;
        errors++;
        $display("FAIL global_timeout at cyc=%0d", cyc);
        summary_and_finish();
    end

endmodule
